// File: rtl/ising_logic_pkg.sv
// -----------------------------------------------------------------------------
// ising_logic_pkg
// Shared configuration for the Ising core logic. It carries the J-memory
// geometry (IsingLogicCfg), the narrow AXI data width, the derived line-packer
// constants, and the line-packer FSM state type.
// -----------------------------------------------------------------------------
package ising_logic_pkg;

    // Width of the narrow AXI data path that feeds each core's J window.
    localparam int unsigned LagdAxiDataWidth = 64;

    typedef struct packed {
        int unsigned JmemDataBitwidth;
        int unsigned JmemAddrBitwidth;
    } ising_logic_cfg_t;

    localparam ising_logic_cfg_t IsingLogicCfg = '{
        JmemDataBitwidth: 256,
        JmemAddrBitwidth: 10
    };

    // Bytes in one J SRAM line, and the number of narrow words in that line.
    localparam int unsigned IcJmemLineBytes    = IsingLogicCfg.JmemDataBitwidth / 8;
    localparam int unsigned IcJmemSlotsPerLine = IsingLogicCfg.JmemDataBitwidth / LagdAxiDataWidth;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } jmem_pack_state_e;

endpackage

// File: rtl/ic_jmem_line_packer_slot_merge.sv
// -----------------------------------------------------------------------------
// ic_slot_merge
// Combinational helper. It places one narrow byte-enabled write into its slot
// of the wide line buffer and ORs the enables into the line byte mask.
//   buf_i / mask_i   : current line buffer and byte mask
//   slot_i           : narrow slot within the line
//   wdata_i / be_i   : narrow write data and byte enables
//   buf_o / mask_o   : merged line buffer and byte mask
// -----------------------------------------------------------------------------
module ic_slot_merge #(
    parameter int unsigned NarrowDw = 64,
    parameter int unsigned WideDw   = 256,
    parameter int unsigned SlotAw   = 2
) (
    input  logic [WideDw-1:0]     buf_i,
    input  logic [WideDw/8-1:0]   mask_i,
    input  logic [SlotAw-1:0]     slot_i,
    input  logic [NarrowDw-1:0]   wdata_i,
    input  logic [NarrowDw/8-1:0] be_i,
    output logic [WideDw-1:0]     buf_o,
    output logic [WideDw/8-1:0]   mask_o
);

    localparam int unsigned NarrowBytes = NarrowDw / 8;
    localparam int unsigned WideBytes   = WideDw / 8;

    logic [WideBytes-1:0] be_wide;

    // NOTE: every output gets a default at the top of the block so that no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        buf_o   = buf_i;
        be_wide = '0;
        be_wide[NarrowBytes-1:0] = be_i;
        for (int b = 0; b < int'(NarrowBytes); b++) begin
            if (be_i[b]) begin
                buf_o[(int'(slot_i) * int'(NarrowBytes) + b) * 8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
        mask_o = mask_i | (be_wide << (int'(slot_i) * int'(NarrowBytes)));
    end

endmodule

// File: rtl/ic_jmem_line_packer.sv
// -----------------------------------------------------------------------------
// ic_jmem_line_packer
// Bridges a core's narrow J-memory port to its wide single-port J SRAM. Narrow
// writes to one line are merged into a line buffer. The buffer is written back
// in one wide access when the line is full, when a conflicting access arrives,
// or on flush_i. Narrow reads go to the SRAM after the buffer is clean, and the
// addressed slot is selected from the returned line.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   req_i/gnt_o       : narrow request / same-cycle grant
//   addr_i, we_i      : byte address in the J window, write select
//   wdata_i, be_i     : narrow write data and byte enables
//   rvalid_o, rdata_o : one response per grant, one cycle later
//   flush_i, idle_o   : write-back request / clean-and-idle status
//   sram_*            : wide SRAM port (read data valid 1 cycle after request)
// -----------------------------------------------------------------------------
module ic_jmem_line_packer
    import ising_logic_pkg::*;
#(
    parameter int unsigned NarrowDw = LagdAxiDataWidth,
    parameter int unsigned WideDw   = IsingLogicCfg.JmemDataBitwidth,
    parameter int unsigned WideAw   = IsingLogicCfg.JmemAddrBitwidth,
    localparam int unsigned LocalAw = WideAw + $clog2(WideDw / 8)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [LocalAw-1:0]    addr_i,
    input  logic                  we_i,
    input  logic [NarrowDw-1:0]   wdata_i,
    input  logic [NarrowDw/8-1:0] be_i,
    output logic                  rvalid_o,
    output logic [NarrowDw-1:0]   rdata_o,
    input  logic                  flush_i,
    output logic                  idle_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [WideAw-1:0]     sram_addr_o,
    output logic [WideDw-1:0]     sram_wdata_o,
    output logic [WideDw/8-1:0]   sram_be_o,
    input  logic [WideDw-1:0]     sram_rdata_i
);

    localparam int unsigned NbAw   = $clog2(NarrowDw / 8);
    localparam int unsigned SlotAw = $clog2(WideDw / NarrowDw);

    jmem_pack_state_e      state_q, state_d;
    logic [WideDw-1:0]     buf_q, buf_d;
    logic [WideDw/8-1:0]   mask_q, mask_d;
    logic [WideAw-1:0]     tag_q, tag_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [SlotAw-1:0]     slot_q, slot_d;
    logic                  rvalid_q, rvalid_d;

    logic [WideAw-1:0]     req_line;
    logic [SlotAw-1:0]     req_slot;
    logic                  dirty;
    logic [WideDw-1:0]     merged_buf;
    logic [WideDw/8-1:0]   merged_mask;
    logic                  unused_addr_bits;

    assign req_line = addr_i[LocalAw-1 -: WideAw];
    assign req_slot = addr_i[NbAw +: SlotAw];
    assign dirty    = |mask_q;
    // Byte offset within a narrow word is carried by be_i, not the address.
    assign unused_addr_bits = ^addr_i[NbAw-1:0];

    ic_slot_merge #(
        .NarrowDw (NarrowDw),
        .WideDw   (WideDw),
        .SlotAw   (SlotAw)
    ) u_slot_merge (
        .buf_i   (buf_q),
        .mask_i  (mask_q),
        .slot_i  (req_slot),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .buf_o   (merged_buf),
        .mask_o  (merged_mask)
    );

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        mask_d       = mask_q;
        tag_d        = tag_q;
        rd_pend_d    = 1'b0;
        slot_d       = slot_q;
        gnt_o        = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;

        unique case (state_q)
            FLUSH: begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = tag_q;
                sram_wdata_o = buf_q;
                sram_be_o    = mask_q;
                mask_d       = '0;
                state_d      = IDLE;
            end
            default: begin
                if (flush_i && dirty) begin
                    // An explicit flush wins over any pending request.
                    state_d = FLUSH;
                end else if (req_i) begin
                    if (we_i) begin
                        if (!dirty || tag_q == req_line) begin
                            gnt_o  = 1'b1;
                            buf_d  = merged_buf;
                            mask_d = merged_mask;
                            tag_d  = req_line;
                            if (&merged_mask) begin
                                state_d = FLUSH;
                            end
                        end else begin
                            state_d = FLUSH;
                        end
                    end else if (dirty) begin
                        // Reads never bypass the buffer: write it back first.
                        state_d = FLUSH;
                    end else begin
                        gnt_o       = 1'b1;
                        sram_req_o  = 1'b1;
                        sram_addr_o = req_line;
                        rd_pend_d   = 1'b1;
                        slot_d      = req_slot;
                    end
                end
            end
        endcase

        rvalid_d = gnt_o;
    end

    // NOTE: state is updated with non-blocking assignments so that every flop
    // samples the values from before the edge, whatever the statement order.
    // NOTE: the line buffer is reset along with its control bits; it is a
    // register, not an SRAM macro, and a defined reset value is expected.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            mask_q    <= '0;
            tag_q     <= '0;
            rd_pend_q <= 1'b0;
            slot_q    <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            mask_q    <= mask_d;
            tag_q     <= tag_d;
            rd_pend_q <= rd_pend_d;
            slot_q    <= slot_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // The SRAM returns data in the response cycle, so the slot select is made
    // here, combinationally, from the registered slot.
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rd_pend_q ? sram_rdata_i[int'(slot_q) * int'(NarrowDw) +: NarrowDw] : '0;
    assign idle_o   = (state_q == IDLE) && !dirty;

endmodule

// File: tb/tb_ic_jmem_line_packer.sv
module tb_ic_jmem_line_packer;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         req_i;
    logic         gnt_o;
    logic [14:0]  addr_i;
    logic         we_i;
    logic [63:0]  wdata_i;
    logic [7:0]   be_i;
    logic         rvalid_o;
    logic [63:0]  rdata_o;
    logic         flush_i;
    logic         idle_o;
    logic         sram_req_o;
    logic         sram_we_o;
    logic [9:0]   sram_addr_o;
    logic [255:0] sram_wdata_o;
    logic [31:0]  sram_be_o;
    logic [255:0] sram_rdata_i = '0;

    typedef struct packed {
        logic [9:0]   addr;
        logic [31:0]  be;
        logic [255:0] wdata;
    } wr_t;

    logic [63:0]  rsp_q[$];
    wr_t          exp_wr_q[$];
    logic [255:0] mem [0:1023];

    int n_total = 0;
    int n_pass  = 0;
    int cyc = 0;
    int sram_wr_cnt = 0;
    int sram_req_cnt = 0;
    int last_wr_cyc = -10;

    ic_jmem_line_packer dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .wdata_i      (wdata_i),
        .be_i         (be_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .flush_i      (flush_i),
        .idle_o       (idle_o),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_be_o    (sram_be_o),
        .sram_rdata_i (sram_rdata_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural wide SRAM: read data appears one cycle after the request.
    always @(posedge clk) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 32; b++)
                    if (sram_be_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
            end else begin
                sram_rdata_i <= mem[sram_addr_o];
            end
        end
    end

    function automatic logic [255:0] be_bits(input logic [31:0] be);
        logic [255:0] m;
        for (int i = 0; i < 256; i++) m[i] = be[i/8];
        return m;
    endfunction

    // Scoreboard: responses and SRAM write-backs are compared as they appear.
    always @(negedge clk) begin
        if (sram_req_o) sram_req_cnt++;
        if (sram_req_o && sram_we_o) begin
            wr_t e;
            logic [255:0] m;
            sram_wr_cnt++;
            last_wr_cyc = cyc;
            n_total++;
            if (exp_wr_q.size() == 0) begin
                $display("FAIL sram_wr_unexpected: got addr=%h be=%h, expected no write", sram_addr_o, sram_be_o);
            end else begin
                e = exp_wr_q.pop_front();
                m = be_bits(e.be);
                if (sram_addr_o !== e.addr || sram_be_o !== e.be || (sram_wdata_o & m) !== (e.wdata & m))
                    $display("FAIL sram_wr: got addr=%h be=%h wdata=%h, expected addr=%h be=%h wdata=%h",
                             sram_addr_o, sram_be_o, sram_wdata_o & m, e.addr, e.be, e.wdata & m);
                else n_pass++;
            end
        end
        if (rvalid_o) begin
            n_total++;
            if (rsp_q.size() == 0) begin
                $display("FAIL rsp_unexpected: got rvalid with rdata=%h, expected none", rdata_o);
            end else begin
                logic [63:0] er;
                er = rsp_q.pop_front();
                if (rdata_o !== er) $display("FAIL rsp_data: got %h expected %h", rdata_o, er);
                else n_pass++;
            end
        end
    end

    // Drive one request until granted; the expected response is queued at grant.
    task automatic do_req(input logic [14:0] a, input logic w, input logic [63:0] d,
                          input logic [7:0] b, input logic [63:0] exp_r,
                          output int stall, output int gcyc);
        req_i = 1'b1; addr_i = a; we_i = w; wdata_i = d; be_i = b;
        stall = 0; gcyc = -1;
        forever begin
            @(negedge clk);
            if (gnt_o === 1'b1) begin
                rsp_q.push_back(w ? 64'h0 : exp_r);
                gcyc = cyc;
                break;
            end
            stall++;
            if (stall > 16) begin
                n_total++;
                $display("FAIL req_timeout: got no grant for addr=%h, expected grant", a);
                break;
            end
        end
        @(posedge clk); #1;
        req_i = 1'b0; we_i = 1'b0; be_i = '0;
    endtask

    task automatic idle_cycles(input int n);
        req_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0;
        wdata_i = '0; be_i = '0; flush_i = 1'b0;
        #3;
        n_total++; if (gnt_o !== 1'b0) $display("FAIL reset_gnt: got %b expected 0", gnt_o); else n_pass++;
        n_total++; if (sram_req_o !== 1'b0) $display("FAIL reset_sram_req: got %b expected 0", sram_req_o); else n_pass++;
        n_total++; if (idle_o !== 1'b1) $display("FAIL reset_idle: got %b expected 1", idle_o); else n_pass++;
        n_total++; if (rvalid_o !== 1'b0) $display("FAIL reset_rvalid: got %b expected 0", rvalid_o); else n_pass++;
        n_total++; if (rdata_o !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", rdata_o); else n_pass++;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_line();
        logic [63:0] v [4];
        int st, gc, c0;
        v[0] = 64'hA0A0_A0A0_0000_000A; v[1] = 64'hB1B1_B1B1_0000_000B;
        v[2] = 64'hC2C2_C2C2_0000_000C; v[3] = 64'hD3D3_D3D3_0000_000D;
        c0 = sram_wr_cnt;
        exp_wr_q.push_back(wr_t'{10'd0, 32'hFFFF_FFFF, {v[3], v[2], v[1], v[0]}});
        for (int i = 0; i < 4; i++) begin
            do_req(15'(i * 8), 1'b1, v[i], 8'hFF, 64'h0, st, gc);
            n_total++; if (st != 0) $display("FAIL full_grant%0d: got %0d stall cycles expected 0", i, st); else n_pass++;
        end
        idle_cycles(3);
        n_total++; if (sram_wr_cnt - c0 != 1) $display("FAIL full_wr_count: got %0d expected 1", sram_wr_cnt - c0); else n_pass++;
        n_total++; if (idle_o !== 1'b1) $display("FAIL full_idle: got %b expected 1", idle_o); else n_pass++;
    endtask

    task automatic test_conflict();
        logic [63:0] x, y;
        int st, gc, c0;
        x = 64'h0123_4567_89AB_CDEF; y = 64'hFEDC_BA98_7654_3210;
        c0 = sram_wr_cnt;
        exp_wr_q.push_back(wr_t'{10'd1, 32'h0000_00FF, {192'h0, x}});
        do_req(15'h20, 1'b1, x, 8'hFF, 64'h0, st, gc);
        do_req(15'h48, 1'b1, y, 8'hFF, 64'h0, st, gc);
        n_total++; if (st < 1) $display("FAIL conflict_stall: got %0d stall cycles expected at least 1", st); else n_pass++;
        n_total++; if (gc != last_wr_cyc + 1) $display("FAIL conflict_grant_cycle: got %0d expected %0d", gc, last_wr_cyc + 1); else n_pass++;
        n_total++; if (sram_wr_cnt - c0 != 1) $display("FAIL conflict_wr_count: got %0d expected 1", sram_wr_cnt - c0); else n_pass++;
        exp_wr_q.push_back(wr_t'{10'd2, 32'h0000_FF00, {128'h0, y, 64'h0}});
        do_flush();
        n_total++; if (sram_wr_cnt - c0 != 2) $display("FAIL conflict_flush_count: got %0d expected 2", sram_wr_cnt - c0); else n_pass++;
    endtask

    task automatic test_read_after_write();
        logic [63:0] k;
        int st, gc;
        k = 64'h1122_3344_5566_7788;
        exp_wr_q.push_back(wr_t'{10'd0, 32'h0000_FF00, {128'h0, k, 64'h0}});
        do_req(15'h08, 1'b1, k, 8'hFF, 64'h0, st, gc);
        do_req(15'h08, 1'b0, 64'h0, 8'h00, k, st, gc);
        n_total++; if (gc != last_wr_cyc + 1) $display("FAIL raw_grant_cycle: got %0d expected %0d", gc, last_wr_cyc + 1); else n_pass++;
        @(negedge clk);
        n_total++; if (rvalid_o !== 1'b1 || rdata_o !== k)
            $display("FAIL raw_latency: got rvalid=%b rdata=%h expected rvalid=1 rdata=%h", rvalid_o, rdata_o, k);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_byte_merge();
        int st, gc, c0;
        c0 = sram_wr_cnt;
        exp_wr_q.push_back(wr_t'{10'd0, 32'h00FF_0000, {64'h0, 64'h2222_2222_1111_1111, 128'h0}});
        do_req(15'h10, 1'b1, 64'hAAAA_AAAA_1111_1111, 8'h0F, 64'h0, st, gc);
        n_total++; if (st != 0) $display("FAIL merge_grant0: got %0d stall cycles expected 0", st); else n_pass++;
        do_req(15'h10, 1'b1, 64'h2222_2222_BBBB_BBBB, 8'hF0, 64'h0, st, gc);
        n_total++; if (st != 0) $display("FAIL merge_grant1: got %0d stall cycles expected 0", st); else n_pass++;
        n_total++; if (idle_o !== 1'b0) $display("FAIL merge_dirty: got idle=%b expected 0", idle_o); else n_pass++;
        do_flush();
        n_total++; if (sram_wr_cnt - c0 != 1) $display("FAIL merge_wr_count: got %0d expected 1", sram_wr_cnt - c0); else n_pass++;
    endtask

    task automatic test_flush_priority();
        logic [63:0] e, f;
        int st, gc, c0;
        e = 64'hEEEE_0000_EEEE_0001; f = 64'hFFFF_0000_FFFF_0002;
        do_req(15'h18, 1'b1, e, 8'hFF, 64'h0, st, gc);
        exp_wr_q.push_back(wr_t'{10'd0, 32'hFF00_0000, {e, 192'h0}});
        flush_i = 1'b1;
        do_req(15'h18, 1'b1, f, 8'hFF, 64'h0, st, gc);
        flush_i = 1'b0;
        n_total++; if (st < 1) $display("FAIL prio_stall: got %0d stall cycles expected at least 1", st); else n_pass++;
        n_total++; if (gc != last_wr_cyc + 1) $display("FAIL prio_grant_cycle: got %0d expected %0d", gc, last_wr_cyc + 1); else n_pass++;
        exp_wr_q.push_back(wr_t'{10'd0, 32'hFF00_0000, {f, 192'h0}});
        do_flush();
        c0 = sram_req_cnt;
        flush_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 flush_i = 1'b0;
        @(posedge clk); #1;
        n_total++; if (sram_req_cnt != c0) $display("FAIL clean_flush: got %0d SRAM accesses expected 0", sram_req_cnt - c0); else n_pass++;
        n_total++; if (idle_o !== 1'b1) $display("FAIL clean_flush_idle: got %b expected 1", idle_o); else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        int st, gc, c0;
        do_req(15'h28, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 64'h0, st, gc);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        #1;
        n_total++; if (sram_req_o !== 1'b1) $display("FAIL rst_pre_flush: got sram_req=%b expected 1", sram_req_o); else n_pass++;
        c0 = sram_wr_cnt;
        rst_i = 1'b1;
        #1;
        n_total++; if (sram_req_o !== 1'b0) $display("FAIL rst_async_drop: got sram_req=%b expected 0", sram_req_o); else n_pass++;
        @(posedge clk); #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (idle_o !== 1'b1) $display("FAIL rst_idle: got %b expected 1", idle_o); else n_pass++;
        n_total++; if (rvalid_o !== 1'b0) $display("FAIL rst_rvalid: got %b expected 0", rvalid_o); else n_pass++;
        n_total++; if (sram_wr_cnt != c0) $display("FAIL rst_no_write: got %0d writes expected 0", sram_wr_cnt - c0); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_full_line();
        test_conflict();
        test_read_after_write();
        test_byte_merge();
        test_flush_priority();
        test_reset_mid_flush();
        n_total++; if (rsp_q.size() != 0 || exp_wr_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d responses and %0d writes outstanding expected 0",
                     rsp_q.size(), exp_wr_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
